// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative read-only instruction cache with round-robin refill
// Optional feature macro: ICACHE_STATS_EN (adds HIT_COUNT / MISS_COUNT lookup counters)
module icache_nway #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int BLOCK_SIZE = 8,
  parameter  int SETS       = 128,
  parameter  int WAYS       = 2,
  localparam int OFF_W      = $clog2(DATA_WIDTH * BLOCK_SIZE / 8),
  localparam int IDX_W      = $clog2(SETS),
  localparam int TAG_W      = ADDR_WIDTH - IDX_W - OFF_W,
  localparam int LINE_W     = DATA_WIDTH * BLOCK_SIZE,
  localparam int WSEL_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        FLUSH,
  input  logic [ADDR_WIDTH-1:0]       ADDR,
  input  logic                        ADDR_VALID,
  output logic                        CACHE_READY,
  output logic [DATA_WIDTH-1:0]       DATA,
  output logic                        DATA_VALID,
  output logic [ADDR_WIDTH-1:0]       ADDR_OUT,
  output logic [ADDR_WIDTH-OFF_W-1:0] ADDR_TO_L2,
  output logic                        ADDR_TO_L2_VALID,
  input  logic                        ADDR_TO_L2_READY,
  input  logic [LINE_W-1:0]           DATA_FROM_L2,
`ifdef ICACHE_STATS_EN
  output logic [31:0]                 HIT_COUNT,
  output logic [31:0]                 MISS_COUNT,
`endif
  input  logic                        DATA_FROM_L2_VALID
);
  localparam int WB_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_REPLAY} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     req_addr_q, req_addr_d;
  logic                      lookup_q, lookup_d;
  logic [ADDR_WIDTH-OFF_W-1:0] l2_addr_q, l2_addr_d;
  logic                      l2_valid_q, l2_valid_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic                      flush_pend_q, flush_pend_d;
  logic [SETS-1:0]           valid_q [WAYS];
  logic [SETS-1:0]           valid_d [WAYS];
  logic [WSEL_W-1:0]         rr_q [SETS];
  logic [WSEL_W-1:0]         rr_d [SETS];

  logic [TAG_W-1:0]          rd_tag [WAYS];
  logic [LINE_W-1:0]         rd_line [WAYS];
  logic [WAYS-1:0]           rd_valid;

  logic [IDX_W-1:0]          req_idx, rd_idx;
  logic [TAG_W-1:0]          req_tag;
  logic [WSEL_W-1:0]         victim;
  logic [WAYS-1:0]           hit_vec;
  logic [DATA_WIDTH-1:0]     hit_word;
  logic                      hit, lookup_miss, accept, rd_en, fill_we;

  assign req_idx     = req_addr_q[OFF_W +: IDX_W];
  assign req_tag     = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign victim      = rr_q[req_idx];
  assign fill_we     = (state_q == S_FILL);
  assign hit         = |hit_vec;
  assign lookup_miss = lookup_q & ~hit;
  assign CACHE_READY = (state_q == S_IDLE) & ~lookup_miss & ~FLUSH & ~flush_pend_q;
  assign accept      = ADDR_VALID & CACHE_READY;
  assign rd_en       = accept | fill_we;
  assign rd_idx      = fill_we ? req_idx : ADDR[OFF_W +: IDX_W];

  assign DATA_VALID       = lookup_q & hit;
  assign DATA             = DATA_VALID ? hit_word : '0;
  assign ADDR_OUT         = DATA_VALID ? req_addr_q : '0;
  assign ADDR_TO_L2       = l2_addr_q;
  assign ADDR_TO_L2_VALID = l2_valid_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];
    logic [TAG_W-1:0]  tag_rd_q;
    logic [LINE_W-1:0] line_rd_q;
    logic              vld_rd_q;
    logic              way_we;

    assign way_we     = fill_we && (int'(victim) == w);
    assign rd_tag[w]  = tag_rd_q;
    assign rd_line[w] = line_rd_q;
    assign rd_valid[w] = vld_rd_q;

    // Sync-read way storage; the filling way forwards its new line so the replay read sees it
    always_ff @(posedge CLK) begin
      if (way_we) begin
        tag_mem[req_idx]  <= req_tag;
        data_mem[req_idx] <= line_q;
      end
      if (rd_en) begin
        tag_rd_q  <= way_we ? req_tag : tag_mem[rd_idx];
        line_rd_q <= way_we ? line_q  : data_mem[rd_idx];
        vld_rd_q  <= way_we ? 1'b1    : valid_q[w][rd_idx];
      end
    end
  end

  // Tag compare across all ways; the lowest matching way supplies the word
  always_comb begin
    hit_vec  = '0;
    hit_word = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = rd_valid[w] && (rd_tag[w] == req_tag);
      if (hit_vec[w]) begin
        hit_word = rd_line[w][int'(req_addr_q[OFF_W-1:WB_W]) * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Miss handling FSM and flush bookkeeping: next-state computation
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    lookup_d     = 1'b0;
    l2_addr_d    = l2_addr_q;
    l2_valid_d   = l2_valid_q;
    line_d       = line_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    rr_d         = rr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_addr_d = ADDR;
          lookup_d   = 1'b1;
        end
        if (lookup_miss) begin
          state_d    = S_REQ;
          l2_valid_d = 1'b1;
          l2_addr_d  = req_addr_q[ADDR_WIDTH-1:OFF_W];
        end
        if (FLUSH || flush_pend_q) begin
          for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
          for (int i = 0; i < SETS; i++) rr_d[i] = '0;
          flush_pend_d = 1'b0;
        end
      end
      S_REQ: begin
        if (ADDR_TO_L2_READY) begin
          l2_valid_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (DATA_FROM_L2_VALID) begin
          line_d  = DATA_FROM_L2;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        for (int w = 0; w < WAYS; w++) begin
          if (int'(victim) == w) valid_d[w][req_idx] = 1'b1;
        end
        rr_d[req_idx] = (victim == WSEL_W'(WAYS - 1)) ? '0 : victim + 1'b1;
        lookup_d = 1'b1;
        state_d  = S_REPLAY;
      end
      S_REPLAY: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && FLUSH) flush_pend_d = 1'b1;
  end

  // Control and valid/round-robin state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      lookup_q     <= 1'b0;
      l2_addr_q    <= '0;
      l2_valid_q   <= 1'b0;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '{default: '0};
      rr_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      lookup_q     <= lookup_d;
      l2_addr_q    <= l2_addr_d;
      l2_valid_q   <= l2_valid_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
    end
  end

  // A line is only ever filled on a miss, so two ways can never match the same tag
  a_single_hit: assert property (@(posedge CLK) disable iff (RST) lookup_q |-> $onehot0(hit_vec));

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating lookup counters; replay lookups are excluded
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == S_IDLE) && lookup_q) begin
      if (hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
      if (!hit && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - randomized and directed bench for icache_nway against a set/way reference model
module tb_icache_nway;
  localparam int SETS = 128;
  localparam int WAYS = 2;
  localparam int LW   = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FLUSH = 1'b0;
  logic [31:0]   ADDR = '0;
  logic          ADDR_VALID = 1'b0;
  logic          CACHE_READY;
  logic [31:0]   DATA;
  logic          DATA_VALID;
  logic [31:0]   ADDR_OUT;
  logic [26:0]   ADDR_TO_L2;
  logic          ADDR_TO_L2_VALID;
  logic          ADDR_TO_L2_READY = 1'b1;
  logic [LW-1:0] DATA_FROM_L2 = '0;
  logic          DATA_FROM_L2_VALID = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0]   HIT_COUNT, MISS_COUNT;
`endif

  icache_nway dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .ADDR(ADDR), .ADDR_VALID(ADDR_VALID),
    .CACHE_READY(CACHE_READY), .DATA(DATA), .DATA_VALID(DATA_VALID), .ADDR_OUT(ADDR_OUT),
    .ADDR_TO_L2(ADDR_TO_L2), .ADDR_TO_L2_VALID(ADDR_TO_L2_VALID),
    .ADDR_TO_L2_READY(ADDR_TO_L2_READY), .DATA_FROM_L2(DATA_FROM_L2),
`ifdef ICACHE_STATS_EN
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
    .DATA_FROM_L2_VALID(DATA_FROM_L2_VALID)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int sb_hits = 0;
  int sb_misses = 0;
  int last_stall = 0;

  logic [26:0] m_line [SETS][WAYS];
  bit          m_vld  [SETS][WAYS];
  int          m_rr   [SETS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    int s = int'(a[11:5]);
    for (int w = 0; w < WAYS; w++) if (m_vld[s][w] && m_line[s][w] == a[31:5]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_fill(input logic [31:0] a);
    int s = int'(a[11:5]);
    int w = m_rr[s];
    m_line[s][w] = a[31:5];
    m_vld[s][w]  = 1'b1;
    m_rr[s]      = (w + 1) % WAYS;
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] l2_word(input logic [26:0] line, input int i);
    return 32'(line) * 32'd8 + 32'(i);
  endfunction

  function automatic logic [LW-1:0] l2_line(input logic [26:0] line);
    logic [LW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = l2_word(line, i);
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, CACHE_READY, 1);
    chk({tag, "_dvalid"}, DATA_VALID, 0);
    chk({tag, "_l2valid"}, ADDR_TO_L2_VALID, 0);
    chk({tag, "_l2addr"}, ADDR_TO_L2, 0);
    chk({tag, "_data"}, DATA, 0);
    chk({tag, "_addrout"}, ADDR_OUT, 0);
`ifdef ICACHE_STATS_EN
    chk({tag, "_hitcnt"}, HIT_COUNT, 0);
    chk({tag, "_misscnt"}, MISS_COUNT, 0);
`endif
  endtask

  // One fetch: accept, serve any L2 request (bp cycles of backpressure with spurious
  // refill pulses, then data k cycles after the handshake), check word and latency.
  task automatic fetch(input logic [31:0] a, input int k, input int bp, input int exp_hit,
                       input bit flush_in_wait);
    int cyc, hs, bpl;
    bit hit, got;
    hit = (exp_hit >= 0) ? bit'(exp_hit) : m_hit(a);
    ADDR = a;
    ADDR_VALID = 1'b1;
    #1;
    cyc = 0;
    while (!CACHE_READY && cyc < 20) begin
      @(negedge CLK); #1; cyc++;
    end
    last_stall = cyc;
    chk("accept_bounded", cyc < 20, 1);
    @(negedge CLK);
    ADDR_VALID = 1'b0;
    ADDR = $urandom;
    #1;
    cyc = 1; hs = -1; bpl = bp; got = 1'b0;
    while (cyc < 60) begin
      if (DATA_VALID) begin
        got = 1'b1;
        break;
      end
      chk("ready_low_during_miss", CACHE_READY, 0);
      FLUSH = flush_in_wait && (hs >= 0) && (cyc == hs + 1);
      if (ADDR_TO_L2_VALID && hs < 0) begin
        chk("l2_addr", ADDR_TO_L2, a[31:5]);
        if (bpl > 0) begin
          ADDR_TO_L2_READY = 1'b0;
          DATA_FROM_L2_VALID = 1'b1;
          DATA_FROM_L2 = {8{$urandom}};
          bpl--;
        end else begin
          ADDR_TO_L2_READY = 1'b1;
          DATA_FROM_L2_VALID = 1'b0;
          hs = cyc;
        end
      end else if (hs >= 0 && cyc == hs + k) begin
        DATA_FROM_L2_VALID = 1'b1;
        DATA_FROM_L2 = l2_line(a[31:5]);
      end else begin
        DATA_FROM_L2_VALID = 1'b0;
      end
      @(negedge CLK); #1; cyc++;
    end
    chk("data_valid_seen", got, 1);
    chk("latency", cyc, hit ? 1 : k + 4 + bp);
    chk("data", DATA, l2_word(a[31:5], int'(a[4:2])));
    chk("addr_out", ADDR_OUT, a);
    if (hit) sb_hits++;
    else begin
      sb_misses++;
      m_fill(a);
      if (flush_in_wait) m_flush();
    end
    FLUSH = 1'b0;
    DATA_FROM_L2_VALID = 1'b0;
    ADDR_TO_L2_READY = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    m_flush();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk_reset_outputs("reset");

    // cold miss with held L2 request, then streaming hits over the whole line
    fetch(32'h0000_0040, 3, 2, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      fetch(32'h0000_0040 + 32'(i * 4), 1, 0, 1, 1'b0);
      if (i > 0) chk("stream_no_stall", last_stall, 0);
    end

    // three lines in set 0 with two ways: round-robin evicts the oldest
    fetch(32'h0000_0000, 1, 0, 0, 1'b0);
    fetch(32'h0000_2000, 2, 0, 0, 1'b0);
    fetch(32'h0000_4000, 1, 0, 0, 1'b0);
    fetch(32'h0000_2004, 1, 0, 1, 1'b0);
    fetch(32'h0000_0008, 2, 0, 0, 1'b0);

    // L2 backpressure with spurious refill pulses while the request is pending
    fetch(32'h0000_8048, 2, 5, 0, 1'b0);
    fetch(32'h0000_804C, 1, 0, 1, 1'b0);

    // flush during a miss, then the same line misses again
    fetch(32'h0000_3000, 2, 0, 0, 1'b1);
    fetch(32'h0000_3004, 1, 0, 0, 1'b0);
    fetch(32'h0000_3008, 1, 0, 1, 1'b0);
    @(negedge CLK); #1;
    @(negedge CLK); #1;
    ADDR = 32'h0000_3000;
    ADDR_VALID = 1'b1;
    FLUSH = 1'b1;
    #1;
    chk("flush_blocks_accept", CACHE_READY, 0);
    @(negedge CLK);
    FLUSH = 1'b0;
    ADDR_VALID = 1'b0;
    #1;
    chk("flush_req_no_data", DATA_VALID, 0);
    @(negedge CLK); #1;
    chk("flush_req_no_l2", ADDR_TO_L2_VALID, 0);
    m_flush();
    fetch(32'h0000_3000, 1, 0, 0, 1'b0);

    // randomized traffic over a few conflicting sets
    for (int n = 0; n < 160; n++) begin
      a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 5)
        | (32'($urandom_range(0, 7)) << 2);
      fetch(a, $urandom_range(1, 4), $urandom_range(0, 2), -1, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 15) == 0) begin
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        m_flush();
        #1;
      end
    end

`ifdef ICACHE_STATS_EN
    chk("stats_hits", HIT_COUNT, sb_hits);
    chk("stats_misses", MISS_COUNT, sb_misses);
`endif

    // reset while waiting for L2; the late refill pulse must be ignored
    @(negedge CLK); #1;
    @(negedge CLK); #1;
    ADDR = 32'h00FF_F020;
    ADDR_VALID = 1'b1;
    #1;
    chk("rst6_accept", CACHE_READY, 1);
    @(negedge CLK);
    ADDR_VALID = 1'b0;
    #1;
    chk("rst6_lookup_miss", DATA_VALID, 0);
    @(negedge CLK); #1;
    chk("rst6_req", ADDR_TO_L2_VALID, 1);
    @(negedge CLK); #1;
    chk("rst6_wait", ADDR_TO_L2_VALID, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk_reset_outputs("rst6");
    m_flush();
    sb_hits = 0;
    sb_misses = 0;
    DATA_FROM_L2_VALID = 1'b1;
    DATA_FROM_L2 = l2_line(27'h007_FFF9);
    @(negedge CLK);
    DATA_FROM_L2_VALID = 1'b0;
    #1;
    chk("late_refill_no_data", DATA_VALID, 0);
    chk("late_refill_no_req", ADDR_TO_L2_VALID, 0);
    chk("late_refill_ready", CACHE_READY, 1);
    fetch(32'h00FF_F020, 2, 0, 0, 1'b0);
    fetch(32'h00FF_F024, 1, 0, 1, 1'b0);
`ifdef ICACHE_STATS_EN
    chk("stats_after_rst_hits", HIT_COUNT, sb_hits);
    chk("stats_after_rst_misses", MISS_COUNT, sb_misses);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
